// File: rtl/aes_pkg.sv
// Shared AES decryption-datapath types, constants and helpers.
package aes_pkg;

  localparam int unsigned AES_NR  = 10;
  localparam int unsigned STATE_W = 128;
  localparam int unsigned ROUND_W = 4;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [ROUND_W-1:0] round_t;

  // Occupancy of a 2-entry skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // InvMixColumns is skipped for the first and last key additions and for
  // any out-of-range index.
  function automatic logic mc_needed(input round_t round, input round_t nr);
    return (round != '0) && (round != nr) && (round <= nr);
  endfunction

endpackage

// File: rtl/aes_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main output register plus one
// skid register, registered in_ready, strict FIFO order.
module aes_skid_buf
  import aes_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, drain;

  assign accept    = in_valid && in_ready_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign drain     = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

  // State register and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next occupancy and data movement; in_ready follows the next state so it
  // never looks at out_ready combinationally.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = SKID_TWO;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    in_ready_d = (state_d != SKID_TWO);
  end

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Registered AddRoundKey stage of the AES decryption datapath, with the
// InvMixColumns enable for the next stage and a sticky bad-index flag.
module inv_add_round_key_stage
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR,
  parameter int unsigned RW = ROUND_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] in_round_key,
  input  logic [RW-1:0]      in_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic [RW-1:0]      out_round,
  output logic               out_mc_en,
  output logic               err
);

  localparam int unsigned   PW   = STATE_W + RW + 1;
  localparam logic [RW-1:0] NR_R = RW'(NR);

  logic          in_fire;
  logic          mc_en;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;
  logic          err_q, err_d;

  assign in_fire    = in_valid && in_ready;
  assign mc_en      = mc_needed(round_t'(in_round), round_t'(NR_R));
  assign in_payload = {in_state ^ in_round_key, in_round, mc_en};

  aes_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_state, out_round, out_mc_en} = out_payload;
  assign err = err_q;

  // Sticky error: set when an out-of-range index is accepted.
  always_comb begin
    err_d = err_q;
    if (in_fire && (in_round > NR_R)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

endmodule
